reg_mux_rr: RTL and testbench

- Parameterised N-channel, W-bit registered multiplexer for the multicycle 16-bit RISC datapath.
- Successor to the combinational 16-bit 2:1 operand mux. Adds a valid/ready handshake per channel and a one-stage output register.
- Two selection modes: externally selected (MODE 0) or round-robin arbitrated (MODE 1).
- Sits between operand/result sources (register file, ALU, memory data) and shared consumers (bus, writeback).

---
 rtl/reg_mux_pkg.sv | 18 +
 rtl/reg_mux_rr_arbiter.sv | 41 ++++
 rtl/reg_mux_rr.sv | 72 +++++++
 tb/tb_reg_mux_rr.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/reg_mux_pkg.sv
// Shared constants and helpers for the registered N:1 datapath mux.
package reg_mux_pkg;
  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  // Channel index width; a 1-bit index is kept even for degenerate N.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/reg_mux_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap, ptr moves past the winner on adv.
module rr_arbiter import reg_mux_pkg::*; #(
  parameter int N = 4,
  localparam int SW = sel_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);
  logic [SW-1:0] ptr;
  logic          found;
  int            idx;

  assign any = |req;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = SW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (adv)
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/reg_mux_rr.sv
// Registered N:1 mux with per-channel valid/ready; channel chosen by sel or round-robin.
module reg_mux_rr import reg_mux_pkg::*; #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int MODE = MUX_MODE_RR,
  localparam int SW  = sel_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);
  logic          load_en;
  logic          capture;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  mux_data;

  // A draining register can refill in the same cycle.
  assign load_en  = ~out_valid | out_ready;
  assign in_ready = rst ? '0 : (gnt & {N{load_en}});
  assign capture  = |(in_valid & in_ready);

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic unused_sel;
    logic any;
    assign unused_sel = ^{sel, any};
    rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (in_valid),
      .adv     (capture),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
    );
  end else begin : g_sel
    // Out-of-range sel matches no channel, so nothing is ever ready.
    always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++)
        gnt[i] = (sel == SW'(i));
    end
    assign gnt_idx = sel;
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data | (in_data[i*W +: W] & {W{gnt[i]}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_mux_rr.sv
// Directed bench: round-robin DUT (N=4) and external-select DUT (N=5, exercises sel>=N).
module tb_reg_mux_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [3:0]    rr_valid, rr_ready;
  logic [63:0]   rr_data;
  logic [1:0]    rr_sel_in, rr_osel;
  logic          rr_ovalid, rr_oready;
  logic [15:0]   rr_odata;

  // External-select instance
  logic [4:0]    m0_valid, m0_ready;
  logic [79:0]   m0_data;
  logic [2:0]    m0_sel_in, m0_osel;
  logic          m0_ovalid, m0_oready;
  logic [15:0]   m0_odata;

  int n_chk  = 0;
  int n_fail = 0;

  reg_mux_rr #(.W(16), .N(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .sel(rr_sel_in), .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel),
    .out_ready(rr_oready));

  reg_mux_rr #(.W(16), .N(5), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .in_valid(m0_valid), .in_data(m0_data), .in_ready(m0_ready),
    .sel(m0_sel_in), .out_valid(m0_ovalid), .out_data(m0_odata), .out_sel(m0_osel),
    .out_ready(m0_oready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic [1:0] s, input logic [15:0] d);
    chk({tag, ".valid"}, 32'(rr_ovalid), 32'd1);
    chk({tag, ".sel"},   32'(rr_osel),   32'(s));
    chk({tag, ".data"},  32'(rr_odata),  32'(d));
  endtask

  initial begin
    rst = 1'b1;
    rr_valid = 4'hF; rr_sel_in = 2'd0; rr_oready = 1'b1;
    for (int i = 0; i < 4; i++) rr_data[i*16 +: 16] = 16'h1000 + 16'(i);
    m0_valid = 5'h1F; m0_sel_in = 3'd0; m0_oready = 1'b1; m0_data = '0;
    tick(); tick();

    // Reset holds everything idle even with every channel valid
    chk("rst.rr_valid", 32'(rr_ovalid), 32'd0);
    chk("rst.rr_data",  32'(rr_odata),  32'd0);
    chk("rst.rr_ready", 32'(rr_ready),  32'd0);
    chk("rst.m0_valid", 32'(m0_ovalid), 32'd0);
    chk("rst.m0_ready", 32'(m0_ready),  32'd0);
    m0_valid = '0;
    rst = 1'b0;
    #1;
    chk("rr.first_ready", 32'(rr_ready), 32'h1);

    // All channels valid: strict rotation, one word per cycle
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_rr($sformatf("rr.rot%0d", k), 2'(k % 4), 16'h1000 + 16'(k % 4));
    end

    // ptr is now 3; only ch1 requests, search wraps to it
    rr_valid = 4'b0010; rr_data[16 +: 16] = 16'hA5A5;
    #1; chk("rr.wrap_ready", 32'(rr_ready), 32'b0010);
    tick(); chk_rr("rr.wrap", 2'd1, 16'hA5A5);
    rr_valid = 4'b0110;
    #1; chk("rr.skip_ready", 32'(rr_ready), 32'b0100);
    tick(); chk_rr("rr.skip", 2'd2, 16'h1002);

    // Back-pressure: full and stalled for three cycles
    rr_valid = 4'hF; rr_oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; chk("rr.bp_ready", 32'(rr_ready), 32'd0);
      tick(); chk_rr($sformatf("rr.bp%0d", k), 2'd2, 16'h1002);
    end
    rr_oready = 1'b1;
    #1; chk("rr.bp_release_ready", 32'(rr_ready), 32'b1000);
    tick(); chk_rr("rr.bp_release", 2'd3, 16'h1003);
    tick(); chk_rr("rr.pre_rst", 2'd0, 16'h1000);

    // Reset mid-stream: held word discarded, ptr back to 0 (ch1 would otherwise win)
    rst = 1'b1;
    #1; chk("rr.midrst_ready", 32'(rr_ready), 32'd0);
    tick();
    chk("rr.midrst_valid", 32'(rr_ovalid), 32'd0);
    chk("rr.midrst_data",  32'(rr_odata),  32'd0);
    rst = 1'b0;
    #1; chk("rr.post_rst_ready", 32'(rr_ready), 32'b0001);
    tick(); chk_rr("rr.post_rst", 2'd0, 16'h1000);
    rr_valid = '0;
    tick();
    chk("rr.drain_valid", 32'(rr_ovalid), 32'd0);
    chk("rr.drain_hold",  32'(rr_odata),  32'h1000);

    // External select: sel=2 picks ch2
    m0_sel_in = 3'd2; m0_valid = 5'b00100; m0_data[2*16 +: 16] = 16'hBEEF;
    m0_data[4*16 +: 16] = 16'h1234;
    #1; chk("m0.sel2_ready", 32'(m0_ready), 32'b00100);
    tick();
    chk("m0.sel2_valid", 32'(m0_ovalid), 32'd1);
    chk("m0.sel2_data",  32'(m0_odata),  32'hBEEF);
    chk("m0.sel2_sel",   32'(m0_osel),   32'd2);
    // Selected channel idle: no capture, register drains, data holds
    m0_sel_in = 3'd3;
    #1; chk("m0.idle_ready", 32'(m0_ready), 32'b01000);
    tick();
    chk("m0.idle_valid", 32'(m0_ovalid), 32'd0);
    chk("m0.idle_hold",  32'(m0_odata),  32'hBEEF);
    // sel beyond N: nothing ready even with all valid
    m0_sel_in = 3'd6; m0_valid = 5'h1F;
    #1; chk("m0.oob_ready", 32'(m0_ready), 32'd0);
    tick();
    chk("m0.oob_valid", 32'(m0_ovalid), 32'd0);
    // Last channel, then a stalled consumer
    m0_sel_in = 3'd4;
    tick();
    chk("m0.sel4_data", 32'(m0_odata), 32'h1234);
    chk("m0.sel4_sel",  32'(m0_osel),  32'd4);
    m0_oready = 1'b0; m0_sel_in = 3'd2;
    #1; chk("m0.bp_ready", 32'(m0_ready), 32'd0);
    tick();
    chk("m0.bp_data",  32'(m0_odata),  32'h1234);
    chk("m0.bp_valid", 32'(m0_ovalid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
